// File: rtl/intr_sel.sv
// Eight-channel interrupt selector: edge-latched requests, mask, offer/ack handshake, one-cycle clear strobe.
// Build option: define INTR_SEL_ROTATE_EN for round-robin selection starting after the last served channel.
module intr_sel (
  input  logic       clk_sys,
  input  logic       clr_,
  input  logic [0:7] rq,
  input  logic       mask_we,
  input  logic [0:7] mask_d,
  input  logic       ack_req,
  output logic       rdy,
  output logic [0:2] vec,
  output logic       ack_ok,
  output logic       dec_en_,
  output logic [0:2] dec_i
);

  // state | meaning
  // IDLE  | nothing offered, waiting for an unmasked pending channel
  // PEND  | rdy high, vec tracks the current selection
  // CLR   | one-cycle decoder strobe clearing pend[vec]
  // WAIT  | ack_ok high until the CPU drops ack_req
  typedef enum logic [1:0] {IDLE, PEND, CLR, WAIT} state_t;

  state_t     state, state_nx;
  logic [0:7] rq_q, pend, pend_nx, mask, cand;
  logic [2:0] sel, idx;
  logic       any_cand;
  logic       rdy_nx, ack_ok_nx, dec_en_nx;
  logic [0:2] vec_nx, dec_i_nx;
`ifdef INTR_SEL_ROTATE_EN
  logic [2:0] last;
`endif

  assign cand = pend & mask;

  // Scan from the farthest offset down so the nearest candidate wins.
  always_comb begin
    sel      = 3'd0;
    idx      = 3'd0;
    any_cand = |cand;
    for (int i = 7; i >= 0; i--) begin
`ifdef INTR_SEL_ROTATE_EN
      idx = last + 3'(i) + 3'd1;
`else
      idx = 3'(i);
`endif
      if (cand[idx]) sel = idx;
    end
  end

  // A new edge on the channel being cleared overrides the clear.
  always_comb begin
    pend_nx = pend;
    if (state == CLR) pend_nx[vec] = 1'b0;
    pend_nx = pend_nx | (rq & ~rq_q);
  end

  always_comb begin
    state_nx  = state;
    rdy_nx    = rdy;
    vec_nx    = vec;
    ack_ok_nx = ack_ok;
    dec_en_nx = 1'b1;
    dec_i_nx  = 3'd0;
    unique case (state)
      IDLE: begin
        if (any_cand) begin
          state_nx = PEND;
          rdy_nx   = 1'b1;
          vec_nx   = sel;
        end
      end
      PEND: begin
        if (ack_req) begin
          state_nx  = CLR;
          rdy_nx    = 1'b0;
          dec_en_nx = 1'b0;
          dec_i_nx  = vec;
        end else if (!any_cand) begin
          state_nx = IDLE;
          rdy_nx   = 1'b0;
        end else begin
          vec_nx = sel;
        end
      end
      CLR: begin
        state_nx  = WAIT;
        ack_ok_nx = 1'b1;
      end
      WAIT: begin
        if (!ack_req) begin
          state_nx  = IDLE;
          ack_ok_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!clr_) begin
      state   <= IDLE;
      rq_q    <= '0;
      pend    <= '0;
      mask    <= '0;
      rdy     <= 1'b0;
      vec     <= 3'd0;
      ack_ok  <= 1'b0;
      dec_en_ <= 1'b1;
      dec_i   <= 3'd0;
`ifdef INTR_SEL_ROTATE_EN
      last    <= 3'd7;
`endif
    end else begin
      state   <= state_nx;
      rq_q    <= rq;
      pend    <= pend_nx;
      if (mask_we) mask <= mask_d;
      rdy     <= rdy_nx;
      vec     <= vec_nx;
      ack_ok  <= ack_ok_nx;
      dec_en_ <= dec_en_nx;
      dec_i   <= dec_i_nx;
`ifdef INTR_SEL_ROTATE_EN
      if (state == CLR) last <= vec;
`endif
    end
  end

endmodule

// File: tb/tb_intr_sel.sv
// Bench for intr_sel: transaction-level reference model checked every cycle plus directed literal checks.
module tb_intr_sel;

  logic       clk_sys = 1'b0;
  logic       clr_;
  logic [0:7] rq, mask_d;
  logic       mask_we, ack_req;
  logic       rdy, ack_ok, dec_en_;
  logic [0:2] vec, dec_i;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  intr_sel dut (
    .clk_sys(clk_sys), .clr_(clr_), .rq(rq), .mask_we(mask_we), .mask_d(mask_d),
    .ack_req(ack_req), .rdy(rdy), .vec(vec), .ack_ok(ack_ok),
    .dec_en_(dec_en_), .dec_i(dec_i)
  );

  always #5 clk_sys = ~clk_sys;

`ifdef INTR_SEL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // Reference model: phase 0 idle, 1 offering, 2 clearing, 3 acknowledged.
  bit [0:7] m_pend, m_rqq, m_mask, edges;
  int m_ph, m_vec, m_last, m_deci, pick;
  bit m_rdy, m_ackok, m_decen;

  function automatic int first_cand(input bit [0:7] c, input int last);
    for (int n = 0; n < 8; n++) begin
      int ch;
      ch = ROT ? (last + 1 + n) % 8 : n;
      if (c[ch]) return ch;
    end
    return -1;
  endfunction

  always @(posedge clk_sys) begin
    if (!clr_) begin
      m_pend = '0; m_rqq = '0; m_mask = '0; m_ph = 0; m_rdy = 0; m_vec = 0;
      m_ackok = 0; m_decen = 1; m_deci = 0; m_last = 7;
    end else begin
      pick  = first_cand(m_pend & m_mask, m_last);
      edges = rq & ~m_rqq;
      m_decen = 1; m_deci = 0;
      if (m_ph == 2) begin
        m_pend[m_vec] = 1'b0;
        m_last = m_vec;
      end
      case (m_ph)
        0: if (pick >= 0) begin m_ph = 1; m_rdy = 1; m_vec = pick; end
        1: begin
          if (ack_req) begin m_ph = 2; m_rdy = 0; m_decen = 0; m_deci = m_vec; end
          else if (pick < 0) begin m_ph = 0; m_rdy = 0; end
          else m_vec = pick;
        end
        2: begin m_ph = 3; m_ackok = 1; end
        default: if (!ack_req) begin m_ph = 0; m_ackok = 0; end
      endcase
      m_pend = m_pend | edges;
      m_rqq  = rq;
      if (mask_we) m_mask = mask_d;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (cmp_on) begin
      chk("model_rdy", int'(rdy), int'(m_rdy));
      chk("model_vec", int'(vec), m_vec);
      chk("model_ack_ok", int'(ack_ok), int'(m_ackok));
      chk("model_dec_en_", int'(dec_en_), int'(m_decen));
      chk("model_dec_i", int'(dec_i), m_deci);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 12 && !rdy; i++) tick();
    chk("wait_rdy", int'(rdy), 1);
  endtask

  task automatic serve();
    ack_req = 1'b1;
    for (int i = 0; i < 12 && !ack_ok; i++) tick();
    chk("wait_ack_ok", int'(ack_ok), 1);
    ack_req = 1'b0;
    tick();
  endtask

  initial begin
    int got[$];
    int exp_order[$];
    clr_ = 1'b0; rq = '0; mask_we = 1'b0; mask_d = '0; ack_req = 1'b0;
    @(posedge clk_sys);
    cmp_on = 1'b1;
    tick(2);
    chk("reset_rdy", int'(rdy), 0);
    chk("reset_dec_en_", int'(dec_en_), 1);
    chk("reset_vec", int'(vec), 0);

    // Basic offer / clear / acknowledge on channel 2
    clr_ = 1'b1; mask_we = 1'b1; mask_d = 8'hFF;
    tick();
    mask_we = 1'b0;
    rq = 8'b00100000;
    tick(2);
    chk("ch2_rdy", int'(rdy), 1);
    chk("ch2_vec", int'(vec), 2);
    ack_req = 1'b1;
    tick();
    chk("ch2_dec_en_", int'(dec_en_), 0);
    chk("ch2_dec_i", int'(dec_i), 2);
    tick();
    chk("ch2_ack_ok", int'(ack_ok), 1);
    chk("ch2_dec_en_off", int'(dec_en_), 1);
    ack_req = 1'b0; rq = '0;
    tick(2);
    chk("ch2_pend_cleared", int'(rdy), 0);

    // Simultaneous edges on 1 and 5
    rq = 8'b01000100;
    tick(2);
    chk("prio_first", int'(vec), 1);
    serve();
    tick();
    chk("prio_second_rdy", int'(rdy), 1);
    chk("prio_second", int'(vec), 5);
    serve();
    rq = '0;
    tick(2);

    // Masking
    mask_we = 1'b1; mask_d = '0;
    tick();
    mask_we = 1'b0; rq = 8'b00010000;
    tick(3);
    chk("masked_rdy", int'(rdy), 0);
    mask_we = 1'b1; mask_d = 8'b00010000;
    tick();
    mask_we = 1'b0;
    tick();
    chk("unmask_rdy", int'(rdy), 1);
    chk("unmask_vec", int'(vec), 3);
    mask_we = 1'b1; mask_d = '0;
    tick(2);
    mask_we = 1'b0;
    chk("remask_rdy", int'(rdy), 0);
    mask_we = 1'b1; mask_d = 8'hFF;
    tick();
    mask_we = 1'b0;
    wait_rdy();
    serve();
    rq = '0;
    tick(2);

    // Edge coinciding with the clear of the same channel
    rq = 8'b00001000;
    tick(2);
    chk("coinc_vec", int'(vec), 4);
    ack_req = 1'b1; rq = '0;
    tick();
    rq = 8'b00001000;
    tick();
    ack_req = 1'b0;
    tick(2);
    chk("coinc_rdy_again", int'(rdy), 1);
    chk("coinc_vec_again", int'(vec), 4);
    serve();
    rq = '0;
    tick(2);

    // Reset during the clear strobe
    rq = 8'b00000001;
    tick(2);
    ack_req = 1'b1;
    tick();
    chk("pre_reset_dec_en_", int'(dec_en_), 0);
    clr_ = 1'b0;
    tick();
    chk("midclr_dec_en_", int'(dec_en_), 1);
    chk("midclr_ack_ok", int'(ack_ok), 0);
    chk("midclr_rdy", int'(rdy), 0);
    clr_ = 1'b1; ack_req = 1'b0;
    tick(3);
    chk("post_reset_mask_zero", int'(rdy), 0);
    rq = '0;
    mask_we = 1'b1; mask_d = 8'hFF;
    tick();
    mask_we = 1'b0;
    wait_rdy();
    chk("held_level_latched", int'(vec), 7);
    serve();
    tick(2);

    // Service order with channels 0 and 6 kept pending
    rq = 8'b10000010;
    for (int k = 0; k < (ROT ? 4 : 2); k++) begin
      wait_rdy();
      got.push_back(int'(vec));
      ack_req = 1'b1;
      for (int i = 0; i < 12 && !ack_ok; i++) tick();
      chk("order_ack_ok", int'(ack_ok), 1);
      rq = '0;
      tick();
      rq = 8'b10000010;
      tick();
      ack_req = 1'b0;
      tick();
    end
    if (ROT) exp_order = '{0, 6, 0, 6};
    else     exp_order = '{0, 0};
    foreach (exp_order[i]) chk("service_order", got[i], exp_order[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
